// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the RX and TX paths.
// Holds the RX FSM state type, legal prescale values, frame sizing and parity.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
  localparam logic [5:0] PRE_8  = 6'd8;
  localparam logic [5:0] PRE_16 = 6'd16;
  localparam logic [5:0] PRE_32 = 6'd32;
  function automatic int frame_bits(input int dw, input logic pen);
    return dw + 2 + int'(pen);
  endfunction
  // Any ratio other than the two larger legal ones falls back to 8.
  function automatic logic [5:0] norm_prescale(input logic [5:0] p);
    return (p == PRE_16 || p == PRE_32) ? p : PRE_8;
  endfunction
  function automatic logic calc_parity(input logic [31:0] d, input logic typ);
    return ^d ^ typ;
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: mid-bit 3-sample majority vote.
// The third sample is the live line at the decision edge, so the vote is ready that same cycle.
module uart_rx_sampler (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] edge_cnt,
  input  logic [5:0] prescale,
  output logic       sampled_bit,
  output logic       sample_done
);
  logic [5:0] w_half;
  logic       r_s0, r_s1;
  assign w_half      = prescale >> 1;
  assign sample_done = edge_cnt == w_half + 6'd1;
  assign sampled_bit = (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else begin
      if (edge_cnt == w_half - 6'd1) r_s0 <= RX_IN;
      if (edge_cnt == w_half) r_s1 <= RX_IN;
    end
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive frame engine (oversampled start/data/parity/stop).
// Strobes fire one cycle after the last stop-bit edge so a new start can be taken in that same cycle.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);
  localparam int BW = $clog2(DATA_WIDTH);
  rx_state_e             r_state;
  logic [5:0]            r_edge, r_pre;
  logic [BW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_pen, r_ptyp, r_perr, r_serr, r_fin;
  logic                  w_bit, w_done, w_last, w_err;
  assign w_last = r_edge == r_pre - 6'd1;
  assign w_err  = r_perr | r_serr;
  uart_rx_sampler u_sampler (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .edge_cnt   (r_edge),
    .prescale   (r_pre),
    .sampled_bit(w_bit),
    .sample_done(w_done)
  );
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_state    <= IDLE;
      r_edge     <= '0;
      r_pre      <= PRE_8;
      r_bit      <= '0;
      r_shift    <= '0;
      r_pen      <= 1'b0;
      r_ptyp     <= 1'b0;
      r_perr     <= 1'b0;
      r_serr     <= 1'b0;
      r_fin      <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= r_fin & ~w_err;
      par_err    <= r_fin & r_perr;
      stp_err    <= r_fin & r_serr;
      if (r_fin && !w_err) P_DATA <= r_shift;
      r_fin  <= 1'b0;
      r_edge <= (r_state == IDLE || w_last) ? '0 : r_edge + 6'd1;
      case (r_state)
        IDLE:
          if (!RX_IN) begin
            r_state <= START;
            r_edge  <= 6'd1;
            r_pre   <= norm_prescale(prescale);
            r_pen   <= PAR_EN;
            r_ptyp  <= PAR_TYP;
            r_bit   <= '0;
            r_perr  <= 1'b0;
            r_serr  <= 1'b0;
          end
        START:
          if (w_done && w_bit) begin
            r_state <= IDLE;
            r_edge  <= '0;
          end else if (w_last) r_state <= DATA;
        DATA: begin
          if (w_done) r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
          if (w_last) begin
            r_bit <= r_bit + 1'b1;
            if (r_bit == BW'(DATA_WIDTH - 1)) r_state <= r_pen ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (w_done) r_perr <= w_bit != calc_parity(32'(r_shift), r_ptyp);
          if (w_last) r_state <= STOP;
        end
        STOP: begin
          if (w_done) r_serr <= ~w_bit;
          if (w_last) begin
            r_state <= IDLE;
            r_fin   <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed bench for uart_rx_frame.
// t0 is the clock edge on which the DUT first sees the start bit low.
module tb_uart_rx_frame;
  import uart_pkg::*;
  logic       CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1;
  logic [5:0] prescale = 6'd16;
  logic       PAR_EN = 1'b0, PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       data_valid, par_err, stp_err;
  int vec = 0, miss = 0, cyc = 0, t0 = 0, g = 0;
  int dv_n = 0, pe_n = 0, se_n = 0, dv_cyc = 0, dv_prev = 0, pe_cyc = 0, se_cyc = 0;
  logic [7:0] dv_data = 8'h00, dv_prev_data = 8'h00;

  uart_rx_frame #(.DATA_WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .prescale  (prescale),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (data_valid) begin
      dv_n++;
      dv_prev = dv_cyc;
      dv_prev_data = dv_data;
      dv_cyc = cyc;
      dv_data = P_DATA;
    end
    if (par_err) begin
      pe_n++;
      pe_cyc = cyc;
    end
    if (stp_err) begin
      se_n++;
      se_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int p, input int gs);
    for (int e = 0; e < p; e++) begin
      RX_IN = (e == gs) ? 1'b0 : v;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Control inputs are scrambled after the start bit to show they are latched.
  task automatic send(input logic [7:0] d, input int p, input logic pen, input logic ptyp,
                      input logic bad_par, input logic stop_v, input logic noise);
    prescale = 6'(p);
    PAR_EN = pen;
    PAR_TYP = ptyp;
    t0 = cyc + 1;
    drive_bit(1'b0, p, -1);
    prescale = 6'd13;
    PAR_EN = ~pen;
    PAR_TYP = ~ptyp;
    for (int i = 0; i < 8; i++)
      drive_bit(d[i], p, (noise && i % 2 == 0 && i < 5) ? p / 2 - 1 + i / 2 : -1);
    if (pen) drive_bit(^d ^ ptyp ^ bad_par, p, -1);
    drive_bit(stop_v, p, -1);
    RX_IN = 1'b1;
  endtask

  initial begin
    idle(3);
    chk("rst_pdata", P_DATA, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_perr", par_err, 0);
    chk("rst_serr", stp_err, 0);
    send(8'h00, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'hFF, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    chk("rst_dv_n", dv_n, 0);
    chk("rst_pe_n", pe_n, 0);
    chk("rst_se_n", se_n, 0);
    chk("rst_pdata_hold", P_DATA, 0);
    RST = 1'b1;
    idle(3);

    send(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    chk("a5_dv_n", dv_n, 1);
    chk("a5_dv_cyc", dv_cyc, t0 + 80);
    chk("a5_dv_data", dv_data, 8'hA5);
    chk("a5_pdata", P_DATA, 8'hA5);
    chk("a5_pe_n", pe_n, 0);
    chk("a5_se_n", se_n, 0);

    send(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(4);
    chk("par_pe_n", pe_n, 1);
    chk("par_pe_cyc", pe_cyc, t0 + 176);
    chk("par_dv_n", dv_n, 1);
    chk("par_pdata", P_DATA, 8'hA5);
    chk("par_se_n", se_n, 0);

    send(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("stp_se_n", se_n, 1);
    chk("stp_se_cyc", se_cyc, t0 + 320);
    chk("stp_dv_n", dv_n, 1);
    chk("stp_pe_n", pe_n, 1);
    chk("stp_pdata", P_DATA, 8'hA5);

    send(8'h97, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(4);
    chk("noise_dv_n", dv_n, 2);
    chk("noise_dv_cyc", dv_cyc, t0 + 160);
    chk("noise_pdata", P_DATA, 8'h97);

    prescale = 6'd16;
    PAR_EN = 1'b0;
    g = cyc + 1;
    RX_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    idle(7);
    send(8'h96, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    chk("glitch_rearm", t0 - g, 10);
    chk("glitch_dv_n", dv_n, 3);
    chk("glitch_dv_cyc", dv_cyc, t0 + 160);
    chk("glitch_pdata", P_DATA, 8'h96);
    chk("glitch_pe_n", pe_n, 1);
    chk("glitch_se_n", se_n, 1);

    send(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    chk("b2b_dv_n", dv_n, 5);
    chk("b2b_gap", dv_cyc - dv_prev, 80);
    chk("b2b_first", dv_prev_data, 8'h55);
    chk("b2b_second", dv_data, 8'hAA);
    chk("b2b_dv_cyc", dv_cyc, t0 + 80);

    prescale = 6'd8;
    PAR_EN = 1'b0;
    drive_bit(1'b0, 8, -1);
    drive_bit(1'b1, 8, -1);
    drive_bit(1'b1, 8, -1);
    drive_bit(1'b0, 8, -1);
    RST = 1'b0;
    #1;
    chk("mid_rst_pdata", P_DATA, 0);
    chk("mid_rst_dv", data_valid, 0);
    chk("mid_rst_perr", par_err, 0);
    chk("mid_rst_serr", stp_err, 0);
    idle(2);
    RST = 1'b1;
    idle(2);
    send(8'hC3, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    chk("post_rst_dv_n", dv_n, 6);
    chk("post_rst_dv_cyc", dv_cyc, t0 + 88);
    chk("post_rst_pdata", P_DATA, 8'hC3);
    chk("post_rst_pe_n", pe_n, 1);
    chk("post_rst_se_n", se_n, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
